// File: rtl/mmcm_drp_rmw.sv
// DRP read-modify-write sequencer for MMCME2_ADV/PLLE2_ADV reconfiguration.
// Applies a table of (addr, keep-mask, data) entries with the MMCM held in reset, then waits for LOCKED.
module mmcm_drp_rmw #(
    parameter int unsigned MAX_ENTRIES  = 23,
    parameter int unsigned IDX_W        = 5,
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic             dclk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [6:0]       cfg_addr,
    input  logic [15:0]      cfg_mask,
    input  logic [15:0]      cfg_data,
    input  logic [IDX_W-1:0] n_entries,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [6:0]       daddr,
    output logic [15:0]      din,
    input  logic [15:0]      dout,
    output logic             den,
    output logic             dwe,
    input  logic             drdy,
    output logic             rst_mmcm,
    input  logic             locked
);

    localparam int unsigned DRDY_CW = $clog2(DRDY_TIMEOUT + 1);
    localparam int unsigned LOCK_CW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned CNT_W   = (LOCK_CW > DRDY_CW) ? LOCK_CW : DRDY_CW;

    localparam logic [IDX_W-1:0] MAX_N     = IDX_W'(MAX_ENTRIES);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        RST_ON,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        RELEASE,
        LOCK_WAIT,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      din_q, din_d;
    logic             den_q, den_d;
    logic             dwe_q, dwe_d;
    logic             rst_mmcm_q, rst_mmcm_d;

    logic [6:0]       tab_addr_q [MAX_ENTRIES];
    logic [15:0]      tab_mask_q [MAX_ENTRIES];
    logic [15:0]      tab_data_q [MAX_ENTRIES];

    logic             tab_we;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] idx_last;
    logic [15:0]      wr_val;
    logic             n_bad;

    assign tab_we   = rst_n && cfg_we && (state_q == IDLE) && (cfg_idx < MAX_N);
    assign idx_nxt  = idx_q + IDX_W'(1);
    assign idx_last = n_q - IDX_W'(1);
    assign wr_val   = (dout & tab_mask_q[idx_q]) | (tab_data_q[idx_q] & ~tab_mask_q[idx_q]);
    assign n_bad    = (n_entries == '0) || (n_entries > MAX_N);

    // Entry table: plain RAM, written only while idle
    always_ff @(posedge dclk) begin
        if (tab_we) begin
            tab_addr_q[cfg_idx] <= cfg_addr;
            tab_mask_q[cfg_idx] <= cfg_mask;
            tab_data_q[cfg_idx] <= cfg_data;
        end
    end

    // Sequencer next-state and registered-output values
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        daddr_d    = daddr_q;
        din_d      = din_q;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        rst_mmcm_d = rst_mmcm_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (start && ready_q) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    n_d     = n_entries;
                    idx_d   = '0;
                    abort_d = 1'b0;
                    if (n_bad) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        error_d = (n_entries > MAX_N);
                    end else begin
                        state_d    = RST_ON;
                        rst_mmcm_d = 1'b1;
                        error_d    = 1'b0;
                    end
                end
            end
            RST_ON: begin
                state_d = RD;
                den_d   = 1'b1;
                daddr_d = tab_addr_q[idx_q];
            end
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                if (drdy) begin
                    state_d = WR;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    din_d   = wr_val;
                end else if (cnt_q == DRDY_LAST) begin
                    state_d    = RELEASE;
                    rst_mmcm_d = 1'b0;
                    abort_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                state_d = WR_WAIT;
                cnt_d   = '0;
            end
            WR_WAIT: begin
                if (drdy) begin
                    if (idx_q == idx_last) begin
                        state_d    = RELEASE;
                        rst_mmcm_d = 1'b0;
                    end else begin
                        idx_d   = idx_nxt;
                        state_d = RD;
                        den_d   = 1'b1;
                        daddr_d = tab_addr_q[idx_nxt];
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    state_d    = RELEASE;
                    rst_mmcm_d = 1'b0;
                    abort_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // LOCKED is not trusted in the cycle reset is dropped
                cnt_d = '0;
                if (abort_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    state_d = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                if (locked) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            daddr_q    <= '0;
            din_q      <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            rst_mmcm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            daddr_q    <= daddr_d;
            din_q      <= din_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            rst_mmcm_q <= rst_mmcm_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign daddr    = daddr_q;
    assign din      = din_q;
    assign den      = den_q;
    assign dwe      = dwe_q;
    assign rst_mmcm = rst_mmcm_q;

endmodule

// File: tb/tb_mmcm_drp_rmw.sv
// Bench for mmcm_drp_rmw: DRP register-file slave, LOCKED model and an access scoreboard
// built from the table contents and plain read-modify-write arithmetic.
module tb_mmcm_drp_rmw;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic        dclk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_idx;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic [4:0]  n_entries;
    logic        start;
    logic        ready, busy, done, error;
    logic [6:0]  daddr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        den, dwe, drdy, rst_mmcm, locked;

    always #5 dclk = ~dclk;

    mmcm_drp_rmw #(
        .MAX_ENTRIES (23),
        .IDX_W       (5),
        .DRDY_TIMEOUT(255),
        .LOCK_TIMEOUT(100)
    ) dut (
        .dclk     (dclk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_addr (cfg_addr),
        .cfg_mask (cfg_mask),
        .cfg_data (cfg_data),
        .n_entries(n_entries),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .daddr    (daddr),
        .din      (din),
        .dout     (dout),
        .den      (den),
        .dwe      (dwe),
        .drdy     (drdy),
        .rst_mmcm (rst_mmcm),
        .locked   (locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Bench view of the table and of the DRP register file
    logic [6:0]  m_addr [23];
    logic [15:0] m_mask [23];
    logic [15:0] m_data [23];
    logic [15:0] drp_reg [128];
    acc_t        log_q[$];
    acc_t        exp_q[$];

    // DRP slave and LOCKED model knobs
    int lat_min = 1, lat_max = 1;
    int hang_read = -1, rd_num = 0;
    bit hang = 0, pend = 0, pend_we = 0;
    logic [6:0] pend_addr;
    int lat_cnt = 0;
    bit lock_en = 1, lock_early = 0;
    int lock_delay = 3;

    // Monitor bookkeeping
    logic rst_smp;
    int   cyc_g = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
    bit   rst_seen = 0;

    always @(posedge dclk) rst_smp <= rst_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // DRP slave: register file with randomised drdy latency, garbage on dout otherwise
    initial begin : slave
        acc_t a;
        bit   was_pend;
        drdy = 1'b0;
        dout = 16'h0;
        forever begin
            @(posedge dclk); #1;
            drdy = 1'b0;
            dout = 16'($urandom);
            if (!rst_smp) begin
                pend = 0;
            end else begin
                was_pend = pend;
                if (pend && !hang) begin
                    if (lat_cnt <= 0) begin
                        drdy = 1'b1;
                        if (!pend_we) dout = drp_reg[pend_addr];
                        pend = 0;
                    end else begin
                        lat_cnt--;
                    end
                end
                if (den) begin
                    chk("single_outstanding", 32'(was_pend), 0);
                    a.we   = dwe;
                    a.addr = daddr;
                    a.data = dwe ? din : 16'h0;
                    log_q.push_back(a);
                    if (dwe) drp_reg[daddr] = din;
                    else begin
                        if (rd_num == hang_read) hang = 1;
                        rd_num++;
                    end
                    pend      = 1;
                    pend_we   = dwe;
                    pend_addr = daddr;
                    lat_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
                end
            end
        end
    end

    // LOCKED model: low while in reset (unless forced early), rises lock_delay cycles after release
    initial begin : lock_model
        int lcnt;
        lcnt   = 0;
        locked = 1'b0;
        forever begin
            @(posedge dclk); #1;
            if (rst_mmcm) begin
                lcnt   = 0;
                locked = lock_early;
            end else if (lcnt < lock_delay) begin
                lcnt++;
                locked = 1'b0;
            end else begin
                locked = lock_en;
            end
        end
    end

    // Every-cycle protocol checks
    initial begin : monitor
        bit den_prev, done_prev, rmm_prev;
        den_prev = 0; done_prev = 0; rmm_prev = 0;
        forever begin
            @(posedge dclk); #1;
            cyc_g++;
            if (!rst_smp) begin
                chk("reset_ctl", {25'h0, ready, busy, done, error, den, dwe, rst_mmcm}, 0);
                chk("reset_bus", {9'h0, daddr, din}, 0);
            end else begin
                chk("busy_is_not_ready", 32'(busy), 32'(!ready));
                if (den)       chk("den_under_rst_mmcm", 32'(rst_mmcm), 1);
                if (dwe)       chk("dwe_with_den", 32'(den), 1);
                if (den_prev)  chk("den_one_cycle", 32'(den), 0);
                if (done_prev) chk("done_one_cycle", 32'(done), 0);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc_g;
                end
                if (rst_mmcm) rst_seen = 1;
                if (rmm_prev && !rst_mmcm) fall_cyc = cyc_g;
            end
            den_prev  = den;
            done_prev = done;
            rmm_prev  = rst_mmcm;
        end
    end

    task automatic load(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        cfg_we = 1'b1; cfg_idx = 5'(i); cfg_addr = a; cfg_mask = m; cfg_data = d;
        @(posedge dclk); #1;
        cfg_we = 1'b0;
        if (i < 23) begin
            m_addr[i] = a; m_mask[i] = m; m_data[i] = d;
        end
    endtask

    // One sequence: expected accesses from the table model, then start, wait, score
    task automatic run_seq(input int n, input bit exp_err, input int exp_len, input bit noise,
                           input int budget, input string tag, output int lat_done);
        logic [15:0] shadow [128];
        acc_t        r;
        logic [15:0] nv;
        int          cyc, d0;
        shadow = drp_reg;
        exp_q.delete();
        if (n >= 1 && n <= 23) begin
            for (int i = 0; i < n; i++) begin
                r.we = 1'b0; r.addr = m_addr[i]; r.data = 16'h0;
                exp_q.push_back(r);
                nv = (shadow[m_addr[i]] & m_mask[i]) | (m_data[i] & ~m_mask[i]);
                shadow[m_addr[i]] = nv;
                r.we = 1'b1; r.data = nv;
                exp_q.push_back(r);
            end
        end
        if (exp_len >= 0) while (exp_q.size() > exp_len) void'(exp_q.pop_back());
        log_q.delete();
        rd_num   = 0;
        rst_seen = 0;
        d0       = done_cnt;
        start     = 1'b1;
        n_entries = 5'(n);
        @(posedge dclk); #1;
        start = 1'b0;
        chk({tag, "_t1_ready"}, 32'(ready), 0);
        chk({tag, "_t1_busy"}, 32'(busy), 1);
        chk({tag, "_t1_error"}, 32'(error), 32'(n > 23));
        chk({tag, "_t1_rst_mmcm"}, 32'(rst_mmcm), 32'(n >= 1 && n <= 23));
        cyc = 0;
        while (!done && cyc < budget) begin
            if (noise) begin
                start    = 1'($urandom);
                cfg_we   = 1'b1;
                cfg_idx  = 5'($urandom_range(2, 0));
                cfg_addr = 7'($urandom);
                cfg_mask = 16'($urandom);
                cfg_data = 16'($urandom);
            end
            @(posedge dclk); #1;
            cyc++;
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        lat_done = cyc;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_rst_mmcm_low"}, 32'(rst_mmcm), 0);
        @(posedge dclk); #1;
        chk({tag, "_ready_after_done"}, 32'(ready), 1);
        repeat (8) @(posedge dclk);
        #1;
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 1);
        chk({tag, "_access_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_acc%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_mask = '0; cfg_data = '0;
        n_entries = '0; start = 1'b0;
        for (int i = 0; i < 128; i++) drp_reg[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
        drp_reg[8] = 16'hFFFF;

        repeat (3) @(posedge dclk);
        #1;
        chk("reset_ready", 32'(ready), 0);
        rst_n = 1'b1;
        @(posedge dclk); #1;
        chk("ready_after_reset", 32'(ready), 1);

        // 1: single entry RMW
        load(0, 7'h08, 16'h1000, 16'h0145);
        lat_min = 2; lat_max = 2;
        run_seq(1, 0, -1, 0, 200, "single", lat);
        chk("single_rd_addr", 32'(log_q.size() > 0 ? log_q[0].addr : 7'h7f), 32'h08);
        chk("single_wr_din", 32'(log_q.size() > 1 ? log_q[1].data : 16'h0), 32'h1145);

        // 2: three entries, variable latency, early LOCKED ignored
        load(1, 7'h09, 16'hFF00, 16'h1234);
        load(2, 7'h08, 16'h0F0F, 16'hABCD);
        lat_min = 1; lat_max = 5; lock_early = 1;
        run_seq(3, 0, -1, 0, 300, "three", lat);
        chk("three_last_din", 32'(log_q.size() > 5 ? log_q[5].data : 16'h0), 32'hA1C5);
        lock_early = 0;

        // 3: second read never completes
        lat_min = 1; lat_max = 3; hang_read = 1;
        run_seq(3, 1, 3, 0, 600, "drdy_to", lat);
        hang_read = -1; hang = 0; pend = 0;

        // 4: LOCKED never rises, error sticky, then cleared by a good run
        lock_en = 0;
        run_seq(1, 1, -1, 0, 400, "lock_to", lat);
        chk("lock_to_window", 32'((done_cyc - fall_cyc) inside {[95:110]}), 1);
        repeat (5) @(posedge dclk);
        #1;
        chk("error_sticky", 32'(error), 1);
        lock_en = 1;
        run_seq(1, 0, -1, 0, 200, "relock", lat);

        // 5: boundary entry counts
        run_seq(0, 0, -1, 0, 20, "n0", lat);
        chk("n0_done_at_t1", 32'(lat), 0);
        chk("n0_no_rst_mmcm", 32'(rst_seen), 0);
        run_seq(24, 1, -1, 0, 20, "n24", lat);
        chk("n24_done_at_t1", 32'(lat), 0);
        chk("n24_no_rst_mmcm", 32'(rst_seen), 0);
        for (int i = 0; i < 23; i++) load(i, 7'(7'h10 + i), 16'($urandom), 16'($urandom));
        load(23, 7'h7f, 16'h0, 16'h0);
        load(31, 7'h7e, 16'h0, 16'h0);
        lat_min = 1; lat_max = 2;
        run_seq(23, 0, -1, 0, 500, "n23", lat);

        // 6: reset during WR_WAIT, then table immune to writes while busy
        lat_min = 4; lat_max = 4;
        log_q.delete(); rd_num = 0;
        start = 1'b1; n_entries = 5'd3;
        @(posedge dclk); #1;
        start = 1'b0;
        lat = 0;
        while (!(den && dwe) && lat < 100) begin
            @(posedge dclk); #1;
            lat++;
        end
        chk("midrst_reached_write", 32'(den && dwe), 1);
        @(posedge dclk); #1;
        rst_n = 1'b0;
        @(posedge dclk); #1;
        chk("midrst_den", 32'(den), 0);
        chk("midrst_rst_mmcm", 32'(rst_mmcm), 0);
        chk("midrst_ready", 32'(ready), 0);
        rst_n = 1'b1;
        @(posedge dclk); #1;
        chk("midrst_ready_after", 32'(ready), 1);
        repeat (6) @(posedge dclk);
        #1;
        lat_min = 1; lat_max = 3;
        run_seq(3, 0, -1, 1, 300, "noisy", lat);
        run_seq(3, 0, -1, 0, 300, "rerun", lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
